// File: rtl/payout_engine_pkg.sv
// Shared definitions for the payout engine: symbol codes, base payout values and FSM states.
package payout_engine_pkg;

    localparam int unsigned SYM_W   = 3;
    localparam int unsigned NUM_SYM = 8;
    localparam int unsigned BASE_W  = 13;

    typedef enum logic [SYM_W-1:0] {
        SYM_BLANK     = 3'd0,
        SYM_CHERRY    = 3'd1,
        SYM_LIME      = 3'd2,
        SYM_ORANGE    = 3'd3,
        SYM_GRAPE     = 3'd4,
        SYM_BANANA    = 3'd5,
        SYM_BLUEBERRY = 3'd6,
        SYM_COCONUT   = 3'd7
    } sym_e;

    localparam logic [BASE_W-1:0] PAY_COCONUT   = 13'd5000;
    localparam logic [BASE_W-1:0] PAY_CHERRY    = 13'd2000;
    localparam logic [BASE_W-1:0] PAY_BLUEBERRY = 13'd1000;
    localparam logic [BASE_W-1:0] PAY_BANANA    = 13'd500;
    localparam logic [BASE_W-1:0] PAY_GRAPE     = 13'd100;
    localparam logic [BASE_W-1:0] PAY_ORANGE    = 13'd25;
    localparam logic [BASE_W-1:0] PAY_LIME      = 13'd10;
    localparam logic [BASE_W-1:0] PAY_TWO_CHERRY = 13'd50;
    localparam logic [BASE_W-1:0] PAY_ONE_CHERRY = 13'd5;
    localparam logic [BASE_W-1:0] PAY_ANY       = 13'd1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_EVAL  = 2'd2,
        ST_SCALE = 2'd3
    } state_e;

endpackage

// File: rtl/payout_base_lookup.sv
// Combinational base payout from per-symbol occurrence counts; first matching rule wins.
module payout_base_lookup
    import payout_engine_pkg::*;
#(
    parameter int unsigned NUM_REELS = 3,
    parameter int unsigned CNT_W     = 2
) (
    input  logic [NUM_SYM-1:0][CNT_W-1:0] counts_i,
    output logic [BASE_W-1:0]             base_c
);

    localparam logic [CNT_W-1:0] ALL_REELS = CNT_W'(NUM_REELS);

    always_comb begin
        base_c = '0;
        if (counts_i[SYM_COCONUT] == ALL_REELS)        base_c = PAY_COCONUT;
        else if (counts_i[SYM_CHERRY] == ALL_REELS)    base_c = PAY_CHERRY;
        else if (counts_i[SYM_BLUEBERRY] == ALL_REELS) base_c = PAY_BLUEBERRY;
        else if (counts_i[SYM_BANANA] == ALL_REELS)    base_c = PAY_BANANA;
        else if (counts_i[SYM_GRAPE] == ALL_REELS)     base_c = PAY_GRAPE;
        else if (counts_i[SYM_ORANGE] == ALL_REELS)    base_c = PAY_ORANGE;
        else if (counts_i[SYM_LIME] == ALL_REELS)      base_c = PAY_LIME;
        else if (counts_i[SYM_CHERRY] >= CNT_W'(2))    base_c = PAY_TWO_CHERRY;
        else if (counts_i[SYM_CHERRY] != '0)           base_c = PAY_ONE_CHERRY;
        else if (counts_i[SYM_BLANK] == '0)            base_c = PAY_ANY;
    end

endmodule

// File: rtl/payout_engine.sv
// Sequential slot payout engine: counts symbols one reel per cycle, looks up and scales the payout.
// Optional progressive jackpot enabled by defining PAYOUT_JACKPOT_EN.
module payout_engine
    import payout_engine_pkg::*;
#(
    parameter int unsigned NUM_REELS    = 3,
    parameter int unsigned BET_W        = 4,
    parameter int unsigned PAY_W        = 16,
    parameter int unsigned JACKPOT_SEED = 100
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [3*NUM_REELS-1:0]   symbols,
    input  logic [BET_W-1:0]         bet,
    output logic                     busy,
    output logic                     done,
    output logic [PAY_W-1:0]         payout,
    output logic                     win,
    output logic [PAY_W-1:0]         jackpot
);

    localparam int unsigned CNT_W  = $clog2(NUM_REELS + 1);
    localparam int unsigned IDX_W  = $clog2(NUM_REELS);
    localparam int unsigned PROD_W = PAY_W + BET_W;
    localparam int unsigned SUM_W  = PROD_W + 1;
    localparam logic [PAY_W-1:0] PAY_MAX = '1;

    if (NUM_REELS < 3 || NUM_REELS > 15) begin : g_bad_reels
        $error("payout_engine: NUM_REELS must be within 3..15");
    end
    if (PAY_W < BASE_W) begin : g_bad_pay_w
        $error("payout_engine: PAY_W must be at least 13");
    end
    if ($clog2(JACKPOT_SEED + 1) > PAY_W) begin : g_bad_seed
        $error("payout_engine: JACKPOT_SEED does not fit in PAY_W");
    end

    state_e                                state_q, state_d;
    logic [NUM_REELS-1:0][SYM_W-1:0]       sym_q, sym_d;
    logic [BET_W-1:0]                      bet_q, bet_d;
    logic [IDX_W-1:0]                      idx_q, idx_d;
    logic [NUM_SYM-1:0][CNT_W-1:0]         cnt_q, cnt_d;
    logic [BASE_W-1:0]                     base_q, base_d;
    logic [PAY_W-1:0]                      payout_q, payout_d;
    logic                                  win_q, win_d;
    logic                                  busy_q, busy_d;
    logic                                  done_q, done_d;
    logic [BASE_W-1:0]                     base_c;
    logic [PROD_W-1:0]                     prod_c;
    logic [SUM_W-1:0]                      total_c;
    logic [PAY_W-1:0]                      sat_c;

    payout_base_lookup #(
        .NUM_REELS (NUM_REELS),
        .CNT_W     (CNT_W)
    ) u_lookup (
        .counts_i (cnt_q),
        .base_c   (base_c)
    );

    assign prod_c = PROD_W'(base_q) * PROD_W'(bet_q);

`ifdef PAYOUT_JACKPOT_EN
    logic [PAY_W-1:0] jackpot_q, jackpot_d;
    logic [PAY_W:0]   jp_sum_c;
    logic             all_coco_c;

    assign all_coco_c = (cnt_q[SYM_COCONUT] == CNT_W'(NUM_REELS));
    assign jp_sum_c   = (PAY_W+1)'(jackpot_q) + (PAY_W+1)'(bet);
    // Pool already contains this spin's bet by the time SCALE runs
    assign total_c    = SUM_W'(prod_c) + (all_coco_c ? SUM_W'(jackpot_q) : SUM_W'(0));
    assign jackpot    = jackpot_q;
`else
    assign total_c    = SUM_W'(prod_c);
    assign jackpot    = '0;
`endif

    assign sat_c = (total_c > SUM_W'(PAY_MAX)) ? PAY_MAX : PAY_W'(total_c);

    // State register and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sym_q     <= '0;
            bet_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            base_q    <= '0;
            payout_q  <= '0;
            win_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef PAYOUT_JACKPOT_EN
            jackpot_q <= PAY_W'(JACKPOT_SEED);
`endif
        end else begin
            state_q   <= state_d;
            sym_q     <= sym_d;
            bet_q     <= bet_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            base_q    <= base_d;
            payout_q  <= payout_d;
            win_q     <= win_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef PAYOUT_JACKPOT_EN
            jackpot_q <= jackpot_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_COUNT;
            ST_COUNT: if (idx_q == IDX_W'(NUM_REELS - 1)) state_d = ST_EVAL;
            ST_EVAL:  state_d = ST_SCALE;
            ST_SCALE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        sym_d     = sym_q;
        bet_d     = bet_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        base_d    = base_q;
        payout_d  = payout_q;
        win_d     = win_q;
        busy_d    = (state_d != ST_IDLE);
        done_d    = 1'b0;
`ifdef PAYOUT_JACKPOT_EN
        jackpot_d = jackpot_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sym_d = symbols;
                    bet_d = bet;
                    idx_d = '0;
                    cnt_d = '0;
`ifdef PAYOUT_JACKPOT_EN
                    jackpot_d = jp_sum_c[PAY_W] ? PAY_MAX : jp_sum_c[PAY_W-1:0];
`endif
                end
            end
            ST_COUNT: begin
                cnt_d[sym_q[idx_q]] = cnt_q[sym_q[idx_q]] + CNT_W'(1);
                idx_d = idx_q + IDX_W'(1);
            end
            ST_EVAL: base_d = base_c;
            ST_SCALE: begin
                payout_d = sat_c;
                win_d    = (sat_c != '0);
                done_d   = 1'b1;
`ifdef PAYOUT_JACKPOT_EN
                if (all_coco_c) jackpot_d = PAY_W'(JACKPOT_SEED);
`endif
            end
            default: ;
        endcase
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign payout = payout_q;
    assign win    = win_q;

endmodule

// File: tb/tb_payout_engine.sv
// Directed self-checking bench for payout_engine; jackpot scenario follows PAYOUT_JACKPOT_EN.
module tb_payout_engine;
    import payout_engine_pkg::*;

    localparam int unsigned N  = 3;
    localparam int unsigned BW = 4;
    localparam int unsigned PW = 16;
    localparam longint      PMAX = 65535;
`ifdef PAYOUT_JACKPOT_EN
    localparam bit     JP   = 1'b1;
    localparam longint SEED = 100;
`else
    localparam bit     JP   = 1'b0;
    localparam longint SEED = 0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [3*N-1:0]  symbols;
    logic [BW-1:0]   bet;
    logic            busy;
    logic            done;
    logic [PW-1:0]   payout;
    logic            win;
    logic [PW-1:0]   jackpot;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint exp_jp;

    payout_engine dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .symbols (symbols),
        .bet     (bet),
        .busy    (busy),
        .done    (done),
        .payout  (payout),
        .win     (win),
        .jackpot (jackpot)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [3*N-1:0] reels(input sym_e a, input sym_e b, input sym_e c);
        return {a, b, c};
    endfunction

    // One full spin: drives start, measures latency, checks result against hand base value
    task automatic spin(input string tag, input logic [3*N-1:0] s, input int b,
                        input longint base, input bit coco);
        longint exp_pay;
        int     edges;
        symbols = s;
        bet     = BW'(b);
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check_eq({tag, "_busy"}, longint'(busy), 1);
        exp_pay = base * b;
        if (JP) begin
            exp_jp = (exp_jp + b > PMAX) ? PMAX : exp_jp + b;
            if (coco) begin
                exp_pay = exp_pay + exp_jp;
                exp_jp  = SEED;
            end
        end
        if (exp_pay > PMAX) exp_pay = PMAX;
        edges = 0;
        while (!done && edges < 20) begin
            @(posedge clk);
            #1 edges++;
        end
        check_eq({tag, "_latency"}, edges, 5);
        check_eq({tag, "_payout"}, longint'(payout), exp_pay);
        check_eq({tag, "_win"}, longint'(win), (exp_pay != 0) ? 1 : 0);
        check_eq({tag, "_jackpot"}, longint'(jackpot), exp_jp);
        @(posedge clk);
        #1;
        check_eq({tag, "_done_pulse"}, longint'(done), 0);
        check_eq({tag, "_idle"}, longint'(busy), 0);
    endtask

    initial begin
        int dones;
        reset   = 1'b1;
        start   = 1'b0;
        symbols = '0;
        bet     = '0;
        exp_jp  = SEED;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", longint'(busy), 0);
        check_eq("rst_done", longint'(done), 0);
        check_eq("rst_payout", longint'(payout), 0);
        check_eq("rst_win", longint'(win), 0);
        check_eq("rst_jackpot", longint'(jackpot), SEED);
        reset = 1'b0;
        @(posedge clk);
        #1;

        spin("coco_b1",   reels(SYM_COCONUT, SYM_COCONUT, SYM_COCONUT), 1, 5000, 1'b1);
        spin("two_cherry", reels(SYM_LIME, SYM_CHERRY, SYM_CHERRY), 3, 50, 1'b0);
        spin("one_cherry", reels(SYM_BLANK, SYM_BLANK, SYM_CHERRY), 2, 5, 1'b0);
        spin("blank_lose", reels(SYM_LIME, SYM_LIME, SYM_BLANK), 5, 0, 1'b0);
        spin("any_nonblank", reels(SYM_GRAPE, SYM_LIME, SYM_ORANGE), 7, 1, 1'b0);
        spin("all_grape", reels(SYM_GRAPE, SYM_GRAPE, SYM_GRAPE), 2, 100, 1'b0);
        spin("bet_zero",  reels(SYM_CHERRY, SYM_CHERRY, SYM_CHERRY), 0, 2000, 1'b0);
        spin("coco_sat",  reels(SYM_COCONUT, SYM_COCONUT, SYM_COCONUT), 15, 5000, 1'b1);

        // Second start during COUNT must be ignored
        symbols = reels(SYM_GRAPE, SYM_LIME, SYM_ORANGE);
        bet     = BW'(7);
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        if (JP) exp_jp = exp_jp + 7;
        @(posedge clk);
        #1;
        symbols = reels(SYM_COCONUT, SYM_COCONUT, SYM_COCONUT);
        bet     = BW'(15);
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1 if (done) dones++;
        end
        check_eq("midstart_dones", dones, 1);
        check_eq("midstart_payout", longint'(payout), 7);
        check_eq("midstart_jackpot", longint'(jackpot), exp_jp);

        // Reset during COUNT aborts the evaluation
        symbols = reels(SYM_COCONUT, SYM_COCONUT, SYM_COCONUT);
        bet     = BW'(1);
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        exp_jp = SEED;
        check_eq("abort_busy", longint'(busy), 0);
        check_eq("abort_done", longint'(done), 0);
        check_eq("abort_payout", longint'(payout), 0);
        check_eq("abort_win", longint'(win), 0);
        check_eq("abort_jackpot", longint'(jackpot), exp_jp);
        @(posedge clk);
        #1 reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 if (done) dones++;
        end
        check_eq("abort_dones", dones, 0);

        // Jackpot accumulation then coconut win (5107 with the pool, 5000 without)
        spin("jp_lose1", reels(SYM_LIME, SYM_LIME, SYM_BLANK), 2, 0, 1'b0);
        spin("jp_lose2", reels(SYM_LIME, SYM_LIME, SYM_BLANK), 2, 0, 1'b0);
        spin("jp_lose3", reels(SYM_LIME, SYM_LIME, SYM_BLANK), 2, 0, 1'b0);
        check_eq("jp_pool", longint'(jackpot), JP ? 106 : 0);
        spin("jp_win", reels(SYM_COCONUT, SYM_COCONUT, SYM_COCONUT), 1, 5000, 1'b1);
        check_eq("jp_win_value", longint'(payout), JP ? 5107 : 5000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
